// File: rtl/avmm_pkg.sv
// Shared Avalon-MM definitions for the pixel-buffer slaves: bus widths and
// the tag carried by each accepted read through the latency pipeline.
package avmm_pkg;

  localparam int AVMM_DATA_W = 16;
  localparam int AVMM_BE_W   = 2;
  localparam int AVMM_ADDR_W = 32;

  typedef struct packed {
    logic                   valid;
    logic                   oob;
    logic [AVMM_ADDR_W-1:0] word_addr;
  } avmm_rd_tag_t;

endpackage

// File: rtl/be_ram.sv
// Pixel store with per-byte write enables and a registered read port.
// The array is never reset so contents survive a bus reset.
module be_ram
  import avmm_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                   clk_i,
  input  logic                   we_i,
  input  logic [AVMM_BE_W-1:0]   be_i,
  input  logic [AW-1:0]          waddr_i,
  input  logic [AVMM_DATA_W-1:0] wdata_i,
  input  logic                   re_i,
  input  logic [AW-1:0]          raddr_i,
  output logic [AVMM_DATA_W-1:0] rdata_o
);

  logic [AVMM_DATA_W-1:0] mem_q [DEPTH];
  logic [AVMM_DATA_W-1:0] rdata_q;

  // A read and a write on the same edge to the same word returns the old word.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < AVMM_BE_W; b++) begin
        if (be_i[b]) begin
          mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/avmm_pixel_slave.sv
// Avalon-MM pipelined-read responder backed by an on-chip pixel buffer,
// with fixed read latency, bounded outstanding reads and a sticky error flag.
module avmm_pixel_slave
  import avmm_pkg::*;
#(
  parameter int MEM_DEPTH    = 1024,
  parameter int READ_LATENCY = 2,
  parameter int MAX_PENDING  = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   chipselect,
  input  logic                   read_n,
  input  logic                   write_n,
  input  logic [AVMM_ADDR_W-1:0] address,
  input  logic [AVMM_BE_W-1:0]   byteenable,
  input  logic [AVMM_DATA_W-1:0] writedata,
  output logic                   waitrequest,
  output logic                   readdatavalid,
  output logic [AVMM_DATA_W-1:0] readdata,
  output logic                   err_oob
);

  localparam int AW = $clog2(MEM_DEPTH);

  logic                   reqRd, reqWr, addrOob;
  logic                   accRd, accWr;
  avmm_rd_tag_t           tagIn, tagLast;
  logic [3:0]             pending_q, pending_d;
  logic                   first_q;
  logic                   rdValid_q, rdOob_q;
  logic                   errOob_q, errOob_d;
  logic [AVMM_DATA_W-1:0] ramRdata;
  logic                   unusedAddrBits;

  assign reqRd   = chipselect & ~read_n;
  assign reqWr   = chipselect & ~write_n;
  assign addrOob = (address >= 32'(MEM_DEPTH));

  // Stall comes from registers only, so the master never sees an input loop.
  assign waitrequest = first_q | (pending_q == 4'(MAX_PENDING));
  assign accWr       = reqWr & ~waitrequest;
  assign accRd       = reqRd & ~reqWr & ~waitrequest;

  assign tagIn = '{valid: accRd, oob: addrOob, word_addr: address};

  generate
    if (READ_LATENCY == 1) begin : gNoStage
      assign tagLast = tagIn;
    end else begin : gStages
      avmm_rd_tag_t tagPipe_q [READ_LATENCY-1];

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          for (int i = 0; i < READ_LATENCY-1; i++) tagPipe_q[i] <= '0;
        end else begin
          tagPipe_q[0] <= tagIn;
          for (int i = 1; i < READ_LATENCY-1; i++) tagPipe_q[i] <= tagPipe_q[i-1];
        end
      end

      assign tagLast = tagPipe_q[READ_LATENCY-2];
    end
  endgenerate

  be_ram #(
    .DEPTH (MEM_DEPTH),
    .AW    (AW)
  ) uRam (
    .clk_i   (clk),
    .we_i    (accWr & ~addrOob),
    .be_i    (byteenable),
    .waddr_i (address[AW-1:0]),
    .wdata_i (writedata),
    .re_i    (tagLast.valid & ~tagLast.oob),
    .raddr_i (tagLast.word_addr[AW-1:0]),
    .rdata_o (ramRdata)
  );

  assign unusedAddrBits = ^{address[AVMM_ADDR_W-1:AW], tagLast.word_addr[AVMM_ADDR_W-1:AW]};

  // A slot is released on the edge that launches its readdatavalid cycle.
  always_comb begin
    pending_d = pending_q;
    if (accRd && !tagLast.valid) begin
      pending_d = pending_q + 4'd1;
    end else if (!accRd && tagLast.valid && (pending_q != 4'd0)) begin
      pending_d = pending_q - 4'd1;
    end
    errOob_d = errOob_q | ((accRd | accWr) & addrOob) | (reqRd & reqWr & ~waitrequest);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending_q <= '0;
      first_q   <= 1'b1;
      rdValid_q <= 1'b0;
      rdOob_q   <= 1'b0;
      errOob_q  <= 1'b0;
    end else begin
      pending_q <= pending_d;
      first_q   <= 1'b0;
      rdValid_q <= tagLast.valid;
      rdOob_q   <= tagLast.oob;
      errOob_q  <= errOob_d;
    end
  end

  assign readdatavalid = rdValid_q;
  assign readdata      = (rdValid_q && !rdOob_q) ? ramRdata : '0;
  assign err_oob       = errOob_q;

endmodule
